// File: rtl/fp32_reciprocal_pack.sv
// Packs a mantissa reciprocal from an upstream core into an IEEE-754 binary32 result.
// Operand sideband is delayed LATENCY cycles so it meets the matching mantissa.
module fp32_reciprocal_pack #(
    parameter int LATENCY = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic [31:0] issue_operand,
    input  logic        mant_valid,
    input  logic [23:0] mant_in,
    output logic        out_valid,
    output logic [31:0] out_result,
    output logic [2:0]  out_flags,
    output logic        align_error
);

    typedef enum logic [1:0] {
        CLS_NORMAL,
        CLS_ZERO,
        CLS_INF,
        CLS_NAN
    } op_class_t;

    typedef struct packed {
        logic      valid;
        logic      sign;
        logic [7:0] exp;
        op_class_t cls;
        logic      snan;
    } side_t;

    side_t              issue_entry;
    side_t              tap;
    side_t              dline [LATENCY];
    logic signed [9:0]  res_exp;
    logic [31:0]        calc_result;
    logic [2:0]         calc_flags;
    logic               unused_mant_msb;

    // mant_in is in (0.5,1.0], so bit 22 is implied whenever bit 23 is clear
    assign unused_mant_msb = mant_in[22];

    always_comb begin
        issue_entry       = '0;
        issue_entry.valid = issue_valid;
        issue_entry.sign  = issue_operand[31];
        issue_entry.exp   = issue_operand[30:23];
        issue_entry.cls   = CLS_NORMAL;
        if (issue_operand[30:23] == 8'd0) begin
            issue_entry.cls = CLS_ZERO;
        end else if (issue_operand[30:23] == 8'hFF) begin
            if (issue_operand[22:0] == 23'd0) begin
                issue_entry.cls = CLS_INF;
            end else begin
                issue_entry.cls  = CLS_NAN;
                issue_entry.snan = ~issue_operand[22];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                dline[i] <= '0;
            end
        end else begin
            dline[0] <= issue_entry;
            for (int i = 1; i < LATENCY; i++) begin
                dline[i] <= dline[i-1];
            end
        end
    end

    assign tap = dline[LATENCY-1];

    always_comb begin
        calc_result = '0;
        calc_flags  = '0;
        if (mant_in[23]) begin
            res_exp = 10'sd254 - $signed({2'b00, tap.exp});
        end else begin
            res_exp = 10'sd253 - $signed({2'b00, tap.exp});
        end
        case (tap.cls)
            CLS_ZERO: begin
                calc_result = {tap.sign, 8'hFF, 23'd0};
                calc_flags  = 3'b010;
            end
            CLS_INF: begin
                calc_result = {tap.sign, 31'd0};
            end
            CLS_NAN: begin
                calc_result = 32'h7FC0_0000;
                calc_flags  = {tap.snan, 2'b00};
            end
            default: begin
                // Results below the normal range flush to signed zero
                if (res_exp <= 10'sd0) begin
                    calc_result = {tap.sign, 31'd0};
                    calc_flags  = 3'b001;
                end else begin
                    calc_result = {tap.sign, res_exp[7:0],
                                   mant_in[23] ? 23'd0 : {mant_in[21:0], 1'b0}};
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_flags   <= '0;
            align_error <= 1'b0;
        end else begin
            out_valid <= mant_valid & tap.valid;
            if (mant_valid && tap.valid) begin
                out_result <= calc_result;
                out_flags  <= calc_flags;
            end
            if (mant_valid != tap.valid) begin
                align_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fp32_reciprocal_pack.sv
// Self-checking bench for fp32_reciprocal_pack: directed vectors, randomized
// back-to-back traffic against a value-level model, and alignment/reset sequences.
module tb_fp32_reciprocal_pack;

    localparam int LAT = 15;
    localparam int NRAND = 24;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [31:0] issue_operand;
    logic        mant_valid;
    logic [23:0] mant_in;
    logic        out_valid;
    logic [31:0] out_result;
    logic [2:0]  out_flags;
    logic        align_error;

    int tests = 0;
    int failed = 0;

    fp32_reciprocal_pack #(.LATENCY(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_operand(issue_operand),
        .mant_valid   (mant_valid),
        .mant_in      (mant_in),
        .out_valid    (out_valid),
        .out_result   (out_result),
        .out_flags    (out_flags),
        .align_error  (align_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] op;
        logic [23:0] mant;
        logic [31:0] exp_result;
        logic [2:0]  exp_flags;
    } vec_t;

    // Reciprocal in value terms: 1/(2^x * 1.f) = 2^-x * m, renormalised when m < 1
    function automatic logic [34:0] model(input logic [31:0] op, input logic [23:0] m);
        int x;
        int biased;
        int frac;
        logic sgn;
        sgn = op[31];
        if (op[30:23] == 8'd0) return {3'b010, sgn, 8'hFF, 23'd0};
        if (op[30:23] == 8'hFF && op[22:0] == 23'd0) return {3'b000, sgn, 31'd0};
        if (op[30:23] == 8'hFF) return {(op[22] ? 3'b000 : 3'b100), 32'h7FC0_0000};
        x = int'(op[30:23]) - 127;
        if (m == 24'h80_0000) begin
            biased = 127 - x;
            frac = 0;
        end else begin
            biased = 127 - x - 1;
            frac = 2 * int'(m) - (1 << 23);
        end
        if (biased <= 0) return {3'b001, sgn, 31'd0};
        return {3'b000, sgn, biased[7:0], frac[22:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0;
        issue_operand = '0;
        mant_valid = 1'b0;
        mant_in = '0;
    endtask

    // Leaves rst=0 driven with no step, so the caller's next drive lands in the first cycle after reset
    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out_result", out_result, 32'd0);
        chk("reset_out_flags", {29'd0, out_flags}, 32'd0);
        chk("reset_align_error", {31'd0, align_error}, 32'd0);
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] op;
        int sel;
        op = $urandom;
        sel = $urandom_range(0, 9);
        case (sel)
            0: op[30:23] = 8'd0;
            1: begin op[30:23] = 8'hFF; op[22:0] = '0; end
            2: begin op[30:23] = 8'hFF; if (op[22:0] == 23'd0) op[0] = 1'b1; end
            3: op[30:23] = 8'($urandom_range(250, 254));
            default: op[30:23] = 8'($urandom_range(1, 254));
        endcase
        return op;
    endfunction

    function automatic logic [23:0] rand_mant();
        if ($urandom_range(0, 4) == 0) return 24'h80_0000;
        return 24'($urandom_range(24'h40_0001, 24'h7F_FFFF));
    endfunction

    vec_t vecs[$];
    logic [31:0] rops[NRAND];
    logic [23:0] rmants[NRAND];

    initial begin
        logic [34:0] m;
        int idx;
        int seen;

        vecs.push_back('{32'h4000_0000, 24'h80_0000, 32'h3F00_0000, 3'b000});
        vecs.push_back('{32'h4040_0000, 24'h55_5555, 32'h3EAA_AAAA, 3'b000});
        vecs.push_back('{32'h8000_0000, 24'h12_3456, 32'hFF80_0000, 3'b010});
        vecs.push_back('{32'h7F80_0001, 24'h80_0000, 32'h7FC0_0000, 3'b100});
        vecs.push_back('{32'hFF80_0000, 24'h55_5555, 32'h8000_0000, 3'b000});
        vecs.push_back('{32'h7F00_0000, 24'h80_0000, 32'h0000_0000, 3'b001});
        vecs.push_back('{32'h7E80_0000, 24'h80_0000, 32'h0080_0000, 3'b000});
        vecs.push_back('{32'h7E80_0000, 24'h7F_FFFF, 32'h0000_0000, 3'b001});
        vecs.push_back('{32'hFF7F_FFFF, 24'h40_0001, 32'h8000_0000, 3'b001});
        vecs.push_back('{32'h3F80_0000, 24'h80_0000, 32'h3F80_0000, 3'b000});
        vecs.push_back('{32'hC000_0000, 24'h80_0000, 32'hBF00_0000, 3'b000});
        vecs.push_back('{32'h0080_0000, 24'h80_0000, 32'h7E80_0000, 3'b000});
        vecs.push_back('{32'h0000_0001, 24'h80_0000, 32'h7F80_0000, 3'b010});
        vecs.push_back('{32'hFFC0_0000, 24'h80_0000, 32'h7FC0_0000, 3'b000});

        do_reset();

        // Directed vectors, one in flight at a time; the first issues right after reset
        foreach (vecs[i]) begin
            issue_valid = 1'b1;
            issue_operand = vecs[i].op;
            step();
            idle_inputs();
            for (int c = 1; c < LAT; c++) step();
            chk("vec_no_early_valid", {31'd0, out_valid}, 32'd0);
            mant_valid = 1'b1;
            mant_in = vecs[i].mant;
            step();
            idle_inputs();
            chk("vec_out_valid", {31'd0, out_valid}, 32'd1);
            chk("vec_result", out_result, vecs[i].exp_result);
            chk("vec_flags", {29'd0, out_flags}, {29'd0, vecs[i].exp_flags});
            step();
            chk("vec_valid_drop", {31'd0, out_valid}, 32'd0);
            chk("vec_result_hold", out_result, vecs[i].exp_result);
        end
        chk("vec_align_error", {31'd0, align_error}, 32'd0);

        // Randomized back-to-back issue with mantissas LAT cycles later
        for (int i = 0; i < NRAND; i++) begin
            rops[i] = rand_operand();
            rmants[i] = rand_mant();
        end
        seen = 0;
        for (int c = 0; c <= NRAND + LAT + 1; c++) begin
            idx = c - LAT - 1;
            if (idx >= 0 && idx < NRAND) begin
                m = model(rops[idx], rmants[idx]);
                chk("rand_out_valid", {31'd0, out_valid}, 32'd1);
                chk("rand_result", out_result, m[31:0]);
                chk("rand_flags", {29'd0, out_flags}, {29'd0, m[34:32]});
                if (out_valid) seen++;
            end else begin
                chk("rand_idle_valid", {31'd0, out_valid}, 32'd0);
            end
            idle_inputs();
            if (c < NRAND) begin
                issue_valid = 1'b1;
                issue_operand = rops[c];
            end
            if (c >= LAT && c - LAT < NRAND) begin
                mant_valid = 1'b1;
                mant_in = rmants[c - LAT];
            end
            step();
        end
        idle_inputs();
        chk("rand_output_count", seen, NRAND);
        chk("rand_align_error", {31'd0, align_error}, 32'd0);

        // Mantissa with no matching issue
        do_reset();
        mant_valid = 1'b1;
        mant_in = 24'h80_0000;
        step();
        idle_inputs();
        chk("orphan_mant_valid", {31'd0, out_valid}, 32'd0);
        chk("orphan_mant_align", {31'd0, align_error}, 32'd1);
        for (int c = 0; c < 4; c++) step();
        chk("orphan_mant_sticky", {31'd0, align_error}, 32'd1);

        // Reset with five operations in flight
        do_reset();
        for (int i = 0; i < 5; i++) begin
            issue_valid = 1'b1;
            issue_operand = 32'h4000_0000 + 32'(i);
            step();
        end
        idle_inputs();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < LAT + 4; c++) begin
            step();
            if (out_valid) seen++;
        end
        chk("flush_no_output", seen, 0);
        chk("flush_align_error", {31'd0, align_error}, 32'd0);

        // Sideband reaches the tap with no mantissa
        issue_valid = 1'b1;
        issue_operand = 32'h4000_0000;
        step();
        idle_inputs();
        seen = 0;
        for (int c = 0; c < LAT + 2; c++) begin
            step();
            if (out_valid) seen++;
        end
        chk("missing_mant_no_output", seen, 0);
        chk("missing_mant_align", {31'd0, align_error}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running required finished");
        $fatal(1, "timeout");
    end

endmodule
